mnist_mlp_wload_seq: RTL

Sequencer in front of the banked MNIST MLP core. It takes one serial weight/bias stream and scatters it round-robin into the per-neuron weight banks and bias memories of the three dense layers. It then issues a start to the core and waits for its completion. It sits between the host/DMA stream and the core's w2/b2/w4/b4/w6/b6 memory write ports, so the core sees fully loaded memories before any inference begins.

---
 rtl/mnist_mlp_wload_seq.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mnist_mlp_wload_seq.sv
// Weight/bias load sequencer for the banked MNIST MLP core.
// Scatters one serial stream round-robin into the per-neuron weight banks and
// bias memories of the three dense layers, then starts the core and waits.
// Optional stream checksum: define MNIST_MLP_WLOAD_CHKSUM_EN.
module mnist_mlp_wload_seq #(
  parameter int unsigned DATA_W    = 18,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_BANKS = 64,
  parameter int unsigned L1_BANKS  = 64,
  parameter int unsigned L1_DEPTH  = 784,
  parameter int unsigned L2_BANKS  = 64,
  parameter int unsigned L2_DEPTH  = 64,
  parameter int unsigned L3_BANKS  = 10,
  parameter int unsigned L3_DEPTH  = 64,
  parameter int unsigned L1_BIAS   = 64,
  parameter int unsigned L2_BIAS   = 64,
  parameter int unsigned L3_BIAS   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 cfg_skip_load,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_vld,
  output logic                 in_rdy,
  output logic [1:0]           mem_layer,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic [MAX_BANKS-1:0] w_we,
  output logic                 b_we,
  output logic                 core_start,
  input  logic                 core_done,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          chksum
);

  localparam int unsigned BANK_W = (MAX_BANKS > 1) ? $clog2(MAX_BANKS) : 1;

  // Load states are consecutive so a finished load state advances by one.
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_W1   = 4'd1;
  localparam logic [3:0] S_B1   = 4'd2;
  localparam logic [3:0] S_W2   = 4'd3;
  localparam logic [3:0] S_B2   = 4'd4;
  localparam logic [3:0] S_W3   = 4'd5;
  localparam logic [3:0] S_B3   = 4'd6;
  localparam logic [3:0] S_RUN  = 4'd7;
  localparam logic [3:0] S_WAIT = 4'd8;
  localparam logic [3:0] S_FIN  = 4'd9;

  logic [3:0]        state, state_nxt;
  logic [BANK_W-1:0] bank_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [BANK_W-1:0] lim_bank;
  logic [ADDR_W-1:0] lim_depth;
  logic [ADDR_W-1:0] lim_bias;
  logic [1:0]        cur_layer;
  logic              is_w, is_b, accept, last_bank, last_waddr, last_bias;
  logic              load_nxt, start_acc;

  // Per-layer geometry selected by the current state.
  always_comb begin
    lim_bank  = BANK_W'(L1_BANKS - 1);
    lim_depth = ADDR_W'(L1_DEPTH - 1);
    lim_bias  = ADDR_W'(L1_BIAS - 1);
    cur_layer = 2'd1;
    case (state)
      S_W2, S_B2: begin
        lim_bank  = BANK_W'(L2_BANKS - 1);
        lim_depth = ADDR_W'(L2_DEPTH - 1);
        lim_bias  = ADDR_W'(L2_BIAS - 1);
        cur_layer = 2'd2;
      end
      S_W3, S_B3: begin
        lim_bank  = BANK_W'(L3_BANKS - 1);
        lim_depth = ADDR_W'(L3_DEPTH - 1);
        lim_bias  = ADDR_W'(L3_BIAS - 1);
        cur_layer = 2'd3;
      end
      default: ;
    endcase
  end

  assign is_w       = (state == S_W1) || (state == S_W2) || (state == S_W3);
  assign is_b       = (state == S_B1) || (state == S_B2) || (state == S_B3);
  assign accept     = in_rdy && in_vld;
  assign last_bank  = (bank_cnt == lim_bank);
  assign last_waddr = (addr_cnt == lim_depth);
  assign last_bias  = (addr_cnt == lim_bias);
  assign start_acc  = (state == S_IDLE) && cfg_start;
  assign load_nxt   = (state_nxt >= S_W1) && (state_nxt <= S_B3);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (cfg_start) state_nxt = cfg_skip_load ? S_RUN : S_W1;
      S_W1, S_W2, S_W3:
        if (accept && last_bank && last_waddr) state_nxt = state + 4'd1;
      S_B1, S_B2, S_B3:
        if (accept && last_bias) state_nxt = state + 4'd1;
      S_RUN:  state_nxt = S_WAIT;
      S_WAIT: if (core_done) state_nxt = S_FIN;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bank/address counters; both end each load state back at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_cnt <= '0;
      addr_cnt <= '0;
    end else if (start_acc) begin
      bank_cnt <= '0;
      addr_cnt <= '0;
    end else if (accept && is_w) begin
      if (last_bank) begin
        bank_cnt <= '0;
        addr_cnt <= last_waddr ? '0 : addr_cnt + ADDR_W'(1);
      end else begin
        bank_cnt <= bank_cnt + BANK_W'(1);
      end
    end else if (accept && is_b) begin
      addr_cnt <= last_bias ? '0 : addr_cnt + ADDR_W'(1);
    end
  end

  // Registered outputs: write port one cycle after acceptance, control pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_rdy     <= 1'b0;
      busy       <= 1'b0;
      core_start <= 1'b0;
      done       <= 1'b0;
      w_we       <= '0;
      b_we       <= 1'b0;
      mem_layer  <= 2'd0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      in_rdy     <= load_nxt;
      busy       <= (state_nxt != S_IDLE);
      core_start <= (state == S_RUN);
      done       <= (state == S_WAIT) && core_done;
      w_we       <= '0;
      b_we       <= 1'b0;
      if (accept) begin
        mem_layer <= cur_layer;
        mem_addr  <= addr_cnt;
        mem_wdata <= in_data;
        if (is_w) w_we <= MAX_BANKS'(1) << bank_cnt;
        else      b_we <= 1'b1;
      end
    end
  end

`ifdef MNIST_MLP_WLOAD_CHKSUM_EN
  // Running sum of sign-extended accepted words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            chksum <= 32'd0;
    else if (start_acc) chksum <= 32'd0;
    else if (accept)    chksum <= chksum + 32'($signed(in_data));
  end
`else
  assign chksum = 32'd0;
`endif

endmodule
